// File: rtl/rr_decode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_decode_arbiter
//  Purpose  : Round-robin arbiter that shares a single 3-to-8 select decoder
//             among eight requesters. The winner's index and the decoder
//             enable are registered. A grant lasts until the owner releases
//             it, withdraws its request, or reaches the hold limit. One dead
//             cycle (GAP) and one arbitration cycle (IDLE) always separate
//             two owners, so the decoder never drives two selects at once.
//  Ports    : clk     - rising-edge clock
//             rst     - asynchronous active-high reset
//             req     - [7:0] request per requester
//             done    - [7:0] release strobe; only the owner's bit is honoured
//             addr    - [2:0] registered owner index (decoder address)
//             en      - registered decoder enable, high only while granted
//             grant   - [7:0] registered one-hot grant, 1 << addr when en
//             busy    - high while granted and during the dead cycle
//             timeout - one-cycle pulse after a hold-limit revocation
//  Params   : MAX_HOLD - maximum grant length in cycles (2..255)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] done,
    output logic [2:0] addr,
    output logic       en,
    output logic [7:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Counter value seen on the last permitted grant cycle.
    localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_addr;
    logic       r_en;
    logic [7:0] r_grant;
    logic [7:0] r_cnt;
    logic       r_busy;
    logic       r_timeout;

    logic       w_found;
    logic [2:0] w_pick;
    logic [2:0] w_idx;
    logic       w_own_done;
    logic       w_own_req;

    // Scan requests starting at the pointer, wrapping modulo 8; the first
    // set bit wins. The 3-bit add provides the wrap for free.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        w_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            w_idx = r_ptr + 3'(i);
            if (!w_found && req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Only the current owner's strobes matter; every other bit is ignored.
    assign w_own_done = done[r_addr];
    assign w_own_req  = req[r_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 3'd0;
            r_addr    <= 3'd0;
            r_en      <= 1'b0;
            r_grant   <= 8'd0;
            r_cnt     <= 8'd0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_addr  <= w_pick;
                        r_en    <= 1'b1;
                        r_grant <= 8'd1 << w_pick;
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Owner release/withdrawal outranks the hold limit, so a
                    // done on the final cycle is a normal release.
                    if (w_own_done || !w_own_req || (r_cnt == c_hold_last)) begin
                        r_timeout <= w_own_req && !w_own_done;
                        r_ptr     <= r_addr + 3'd1;
                        r_en      <= 1'b0;
                        r_grant   <= 8'd0;
                        r_state   <= ST_GAP;
                    end else if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_en    <= 1'b0;
                    r_grant <= 8'd0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign addr    = r_addr;
    assign en      = r_en;
    assign grant   = r_grant;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_decode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_decode_arbiter
//  Purpose  : Self-checking bench for rr_decode_arbiter (MAX_HOLD = 4).
//             A phase/owner/held-cycle model predicts the outputs every
//             cycle; directed scenarios add hand-computed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_decode_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'd0;
    logic [7:0] done = 8'd0;
    logic [2:0] addr;
    logic       en;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .addr    (addr),
        .en      (en),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: phase 0 = idle, 1 = owner holds the decoder, 2 = dead cycle.
    // m_held counts grant cycles already served by the owner.
    // ------------------------------------------------------------------
    int m_phase = 0;
    int m_owner = 0;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_owner = 0; m_held = 0; m_ptr = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            case (m_phase)
                0: begin
                    if (req != 8'd0) begin
                        for (int k = 0; k < 8; k++) begin
                            if (req[(m_ptr + k) % 8]) begin
                                m_owner = (m_ptr + k) % 8;
                                break;
                            end
                        end
                        m_held  = 1;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (done[m_owner] || !req[m_owner]) begin
                        m_ptr = (m_owner + 1) % 8; m_phase = 2;
                    end else if (m_held == MAX_HOLD) begin
                        m_to = 1'b1;
                        m_ptr = (m_owner + 1) % 8; m_phase = 2;
                    end else begin
                        m_held++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            logic       exp_en;
            logic [7:0] exp_grant;
            exp_en    = (m_phase == 1);
            exp_grant = exp_en ? 8'(1 << m_owner) : 8'd0;
            check("model_en", en, exp_en);
            check("model_grant", grant, exp_grant);
            check("model_busy", busy, m_phase != 0);
            check("model_timeout", timeout, m_to);
            check("onehot", $countones(grant) <= 1, 1);
            if (exp_en) check("model_addr", addr, m_owner);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        req = 8'd0; done = 8'd0; rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp;
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("reset_en", en, 0);
        check("reset_grant", grant, 8'h00);
        check("reset_addr", addr, 0);
        check("reset_busy", busy, 0);
        check("reset_timeout", timeout, 0);
        rst = 1'b0;
        started = 1'b1;

        // Reset mid-grant, then re-arbitrate from ptr 0.
        req = 8'h20; cyc(1);
        check("t1_grant", grant, 8'h20);
        check("t1_addr", addr, 5);
        cyc(1);
        #2 rst = 1'b1; #1;
        check("t1_rst_en", en, 0);
        check("t1_rst_grant", grant, 8'h00);
        check("t1_rst_addr", addr, 0);
        check("t1_rst_busy", busy, 0);
        rst = 1'b0;
        cyc(1);
        check("t1_regrant", grant, 8'h20);

        // Round robin with done on each owner's 3rd grant cycle.
        do_reset();
        req = 8'hFF; cyc(1);
        for (int g = 0; g < 9; g++) begin
            exp = 8'(1 << (g % 8));
            check("rr_grant", grant, exp);
            cyc(2);
            done = exp; cyc(1); done = 8'd0;
            check("rr_release", en, 0);
            if (g < 8) begin
                n = 0;
                while (en !== 1'b1 && n < 10) begin cyc(1); n++; end
                check("rr_dead_cycles", n, 2);
            end
        end

        // Pointer wrap: after owner 6, scan 7,0 picks 0; then 6 again.
        do_reset();
        req = 8'h40; cyc(1);
        check("wrap_first", grant, 8'h40);
        done = 8'h40; cyc(1); done = 8'd0;
        req = 8'h41; cyc(2);
        check("wrap_to_0", grant, 8'h01);
        done = 8'h01; cyc(1); done = 8'd0;
        cyc(2);
        check("wrap_back_6", grant, 8'h40);

        // Timeout with MAX_HOLD = 4.
        do_reset();
        req = 8'h08; cyc(1);
        check("to_grant", grant, 8'h08);
        n = 0;
        while (en === 1'b1 && n < 20) begin n++; cyc(1); end
        check("to_len", n, 4);
        check("to_pulse", timeout, 1);
        check("to_busy_gap", busy, 1);
        cyc(1);
        check("to_pulse_end", timeout, 0);
        cyc(1);
        check("to_regrant", grant, 8'h08);

        // Foreign done ignored; withdrawal releases without timeout, ptr=3.
        do_reset();
        req = 8'h04; cyc(1);
        check("wd_grant", grant, 8'h04);
        done = 8'h10; cyc(1); done = 8'd0;
        check("wd_foreign_done", grant, 8'h04);
        req = 8'h00; cyc(1);
        check("wd_release", grant, 8'h00);
        check("wd_no_timeout", timeout, 0);
        req = 8'h0C; cyc(2);
        check("wd_ptr3", grant, 8'h08);

        // done on the final permitted cycle: normal release, no timeout.
        do_reset();
        req = 8'h02; cyc(1);
        check("sim_grant", grant, 8'h02);
        cyc(3);
        check("sim_still_held", grant, 8'h02);
        done = 8'h02; cyc(1); done = 8'd0;
        check("sim_release", en, 0);
        check("sim_no_timeout", timeout, 0);
        req = 8'd0;
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
